// File: rtl/r_prefetch.sv
// Read-side prefetch stage: converts the FIFO read port (rinc/rempty, rdata one
// cycle later) into a first-word-fall-through valid/ready stream. Two buffer
// entries plus an in-flight read let it sustain one word per cycle.
module r_prefetch #(
  parameter int unsigned DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] rdata,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [1:0]          level
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  occ_e                occ_q, occ_d;
  logic                inflight_q, inflight_d;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] used;

  // Read credit, buffer occupancy and entry updates.
  always_comb begin
    dout_valid = (occ_q != StEmpty);
    pop        = dout_valid & dout_ready;
    push       = inflight_q;
    // Slots committed after this cycle's pop; pop implies occ >= 1, so no underflow.
    used       = 2'(occ_q) + 2'(inflight_q) - 2'(pop);
    rinc       = !rrst && !rempty && (used < 2'd2);
    issue      = rinc & !rempty;

    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = issue;

    unique case (occ_q)
      StEmpty: begin
        if (push) begin
          head_d = rdata;
          occ_d  = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = rdata;
        end else if (push) begin
          tail_d = rdata;
          occ_d  = StTwo;
        end else if (pop) begin
          occ_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = rdata;
            occ_d  = StTwo;
          end else begin
            occ_d = StOne;
          end
        end
      end
      default: occ_d = StEmpty;
    endcase
  end

  // State registers with synchronous reset; reset also drops any in-flight word.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q      <= StEmpty;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign dout  = head_q;
  assign level = occ_q;

endmodule

// File: tb/tb_r_prefetch.sv
// Bench for r_prefetch: a vector table for reset / single-word / pop+push /
// mid-operation reset, then a FIFO model with a scoreboard for streaming,
// backpressure and random traffic.
module tb_r_prefetch;

  logic       clk;
  logic       rrst;
  logic       rempty;
  logic       rinc;
  logic [7:0] rdata;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [1:0] level;

  r_prefetch #(.DATASIZE(8)) dut (
    .rclk      (clk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rrst;
    logic       rempty;
    logic       rdy;
    logic [7:0] rdata;
    logic       e_rinc;
    logic       e_valid;
    logic [1:0] e_level;
    logic       chk_dout;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl [18];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo  [$];
  logic [7:0] exp_q [$];
  logic       pend;
  logic [7:0] pend_data;
  int iss_cnt, iss_run, iss_max, pop_run, pop_max;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the FIFO model: drives inputs at negedge, checks, steps to next negedge.
  task automatic sb_cycle(input logic fe, input logic rdy);
    logic       popped;
    logic       iss;
    logic       e_rinc;
    logic [7:0] w;
    int         occ_m;
    w          = 8'h00;
    rrst       = 1'b0;
    rempty     = fe | (fifo.size() == 0);
    dout_ready = rdy;
    rdata      = pend ? pend_data : 8'($urandom);
    #1;
    occ_m  = exp_q.size() - int'(pend);
    popped = dout_valid & dout_ready;
    iss    = rinc & !rempty;
    check("level", 32'(level), 32'(occ_m));
    check("dout_valid", 32'(dout_valid), 32'(occ_m != 0));
    check("credit", 32'((int'(level) + int'(pend)) <= 2), 32'd1);
    e_rinc = !rempty && ((int'(level) + int'(pend) - int'(popped)) < 2);
    check("rinc", 32'(rinc), 32'(e_rinc));
    if (dout_valid && exp_q.size() > 0) check("dout_order", 32'(dout), 32'(exp_q[0]));
    if (popped && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pop_run++;
      if (pop_run > pop_max) pop_max = pop_run;
    end else begin
      pop_run = 0;
    end
    if (iss) begin
      w = fifo.pop_front();
      exp_q.push_back(w);
      iss_cnt++;
      iss_run++;
      if (iss_run > iss_max) iss_max = iss_run;
    end else begin
      iss_run = 0;
    end
    @(posedge clk);
    pend      = iss;
    pend_data = w;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    iss_cnt = 0;
    iss_run = 0;
    iss_max = 0;
    pop_run = 0;
    pop_max = 0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || pend) && k < budget) begin
      sb_cycle(1'b0, 1'b1);
      k++;
    end
    check("drain_done", 32'(fifo.size() == 0 && exp_q.size() == 0 && !pend), 32'd1);
  endtask

  initial begin
    //          rrst  remp  rdy   rdata  rinc  vld   lvl    chk   dout
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1, 8'hA5};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 8'h11};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 2'd1, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1, 8'h22};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 2'd1, 1'b1, 8'h22};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2'd2, 1'b1, 8'h22};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 2'd1, 1'b1, 8'h33};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00};

    rrst       = 1'b1;
    rempty     = 1'b1;
    dout_ready = 1'b0;
    rdata      = 8'h00;
    pend       = 1'b0;
    pend_data  = 8'h00;
    clear_stats();
    @(posedge clk);
    @(negedge clk);

    // Directed vectors: reset, single word, pop+push at level 1, reset mid-operation.
    for (int i = 0; i < 18; i++) begin
      rrst       = tbl[i].rrst;
      rempty     = tbl[i].rempty;
      dout_ready = tbl[i].rdy;
      rdata      = tbl[i].rdata;
      #1;
      check($sformatf("vec%0d_rinc", i), 32'(rinc), 32'(tbl[i].e_rinc));
      check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].e_level));
      if (tbl[i].chk_dout) check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      @(posedge clk);
      @(negedge clk);
    end

    // Continuous stream of 16 words with dout_ready held high.
    clear_stats();
    for (int i = 1; i <= 16; i++) fifo.push_back(8'(i));
    drain(60);
    check("stream_rinc_run", 32'(iss_max), 32'd16);
    check("stream_pop_run", 32'(pop_max), 32'd16);

    // Backpressure: exactly two reads, then stall at level 2.
    clear_stats();
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(i));
    repeat (6) sb_cycle(1'b0, 1'b0);
    check("bp_reads", 32'(iss_cnt), 32'd2);
    check("bp_level", 32'(level), 32'd2);
    check("bp_rinc", 32'(rinc), 32'd0);
    check("bp_head", 32'(dout), 32'h01);
    drain(60);

    // Random traffic with random empty flag and consumer stalls.
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      if (fifo.size() < 4 && ($urandom % 2) == 0) fifo.push_back(8'($urandom));
      sb_cycle(($urandom % 4) == 0, ($urandom % 3) != 0);
    end
    drain(100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
